// File: rtl/proc_pkg.sv
// Shared processor definitions: datapath width, stack bounds, stack-op encoding.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package proc_pkg;

    localparam int DATA_W = 8;

    localparam logic [DATA_W-1:0] STACK_TOP_DEF    = 8'hFF;
    localparam logic [DATA_W-1:0] STACK_BOTTOM_DEF = 8'hC0;

    // Stack-pointer operation selected for one pipeline slot, shared with the CCG stages
    typedef enum logic [2:0] {
        SP_HOLD     = 3'd0,
        SP_LOAD     = 3'd1,
        SP_PUSH     = 3'd2,
        SP_POP      = 3'd3,
        SP_CONFLICT = 3'd4
    } sp_op_t;

    // Priority decode of the raw strobes: load beats everything, push+pop together is a conflict
    function automatic sp_op_t decode_sp_op(input logic lsp, input logic dsp, input logic isp);
        sp_op_t op;
        if (lsp)
            op = SP_LOAD;
        else if (dsp && isp)
            op = SP_CONFLICT;
        else if (dsp)
            op = SP_PUSH;
        else if (isp)
            op = SP_POP;
        else
            op = SP_HOLD;
        return op;
    endfunction

endpackage

// File: rtl/sp_bound_check.sv
// Flags whether a stack pointer sits at the empty (top) or full (bottom) limit.
// Latency: combinational, zero cycles.
// Backpressure: none; pure compare.
module sp_bound_check
    import proc_pkg::*;
#(
    parameter int                  BC_W      = proc_pkg::DATA_W,
    parameter logic [BC_W-1:0]     BC_TOP    = proc_pkg::STACK_TOP_DEF,
    parameter logic [BC_W-1:0]     BC_BOTTOM = proc_pkg::STACK_BOTTOM_DEF
) (
    input  logic [BC_W-1:0] sp,
    output logic            at_top,
    output logic            at_bottom
);

    // Equality compares only: out-of-range values loaded via LSP are neither top nor bottom
    always_comb begin
        at_top    = (sp == BC_TOP);
        at_bottom = (sp == BC_BOTTOM);
    end

endmodule

// File: rtl/stack_pointer_unit.sv
// Write-back stack pointer: pre-decrement push, post-increment pop, load, overflow/underflow trap.
// Latency: sp_addr/push_block combinational; sp_value and flags update on the next clk edge.
// Backpressure: none; stall freezes SP and flags, strobes are single-cycle with no handshake.
module stack_pointer_unit
    import proc_pkg::*;
#(
    parameter int                    DATA_W       = proc_pkg::DATA_W,
    parameter logic [DATA_W-1:0]     STACK_TOP    = proc_pkg::STACK_TOP_DEF,
    parameter logic [DATA_W-1:0]     STACK_BOTTOM = proc_pkg::STACK_BOTTOM_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              LSP,
    input  logic              DSP,
    input  logic              ISP,
    input  logic              stall,
    input  logic              clr_flags,
    input  logic [DATA_W-1:0] sp_load_data,
    output logic [DATA_W-1:0] sp_addr,
    output logic [DATA_W-1:0] sp_value,
    output logic              push_block,
    output logic              ovf,
    output logic              udf,
    output logic              conflict
);

    logic [DATA_W-1:0] sp_q;
    logic              at_top;
    logic              at_bottom;
    sp_op_t            op;
    logic              set_ovf;
    logic              set_udf;

    sp_bound_check #(
        .BC_W      (DATA_W),
        .BC_TOP    (STACK_TOP),
        .BC_BOTTOM (STACK_BOTTOM)
    ) u_bound (
        .sp        (sp_q),
        .at_top    (at_top),
        .at_bottom (at_bottom)
    );

    // Decode the slot's operation and form the same-cycle memory address
    always_comb begin
        op         = decode_sp_op(LSP, DSP, ISP);
        push_block = (op == SP_PUSH) && at_bottom;
        set_ovf    = (op == SP_PUSH) && at_bottom;
        set_udf    = (op == SP_POP)  && at_top;
        // Address decrements on any DSP that is not blocked, so a push writes below the current SP
        if (DSP && !push_block)
            sp_addr = sp_q - DATA_W'(1);
        else
            sp_addr = sp_q;
    end

    assign sp_value = sp_q;

    // SP, sticky flags and conflict pulse; stall freezes state and drops the pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q     <= STACK_TOP;
            ovf      <= 1'b0;
            udf      <= 1'b0;
            conflict <= 1'b0;
        end else if (stall) begin
            conflict <= 1'b0;
        end else begin
            conflict <= (op == SP_CONFLICT);
            // A new trap in the same cycle as clr_flags keeps the flag set
            ovf      <= set_ovf | (ovf & ~clr_flags);
            udf      <= set_udf | (udf & ~clr_flags);
            case (op)
                SP_LOAD: sp_q <= sp_load_data;
                SP_PUSH: if (!at_bottom) sp_q <= sp_q - DATA_W'(1);
                SP_POP:  if (!at_top)    sp_q <= sp_q + DATA_W'(1);
                default: sp_q <= sp_q;
            endcase
        end
    end

endmodule
